// File: rtl/ram_burst_reader_pkg.sv
// Shared types and constants for the RAM burst reader and its output FIFO.
package ram_burst_reader_pkg;

  // Output FIFO depth. This is also the credit limit for reads that are
  // still in flight or not yet consumed.
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  // State codes are kept as plain constants so that older code can still
  // compare against raw values.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_ISSUE = ISSUE,
    S_DRAIN = DRAIN
  } state_e;

  // One tag per RAM pipeline stage. The tag records whether the stage holds
  // a real read and whether that read is the last word of the burst.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// Small synchronous FIFO holding {last, data} words returned by the RAM.
// The head entry is presented combinationally; count is exported so the
// reader can apply its credit rule.
module ram_burst_reader_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;
  logic             full;

  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset on purpose: the head entry drives the
      // stream data pins directly, and those must read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: every register here uses <= so all of them update from the
      // values seen before the edge; blocking = would create ordering races.
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The reader's credit rule guarantees a free slot for every returning read.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for one port of a block RAM with 1 or 2 cycles of
// enabled read latency. A command (start address, length-1) is turned into
// a sequence of RAM reads; a tag pipe that moves in step with the RAM's
// enable tracks which returning words are real, and a 4-entry FIFO
// re-times them onto a valid/ready stream with tlast on the final word.
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH-1:0] cmd_len,
  output logic              ram_en,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [DWIDTH-1:0] o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready
);

  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_rd_latency
    $error("ram_burst_reader: RD_LATENCY must be 1 or 2");
  end

  state_e            state;
  state_e            state_nxt;
  logic [AWIDTH-1:0] addr;
  logic [AWIDTH-1:0] remaining;
  tag_t              tag_pipe [RD_LATENCY];
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              cmd_accept;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [DWIDTH:0]   fifo_head;

  assign cmd_ready  = (state == S_IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  // Every word issued to the RAM holds either a pipe stage or a FIFO slot
  // until it is consumed, so capping the sum at the FIFO depth means a
  // returning word always finds room.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state == S_ISSUE) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign last_issue  = issue && (remaining == '0);

  // The RAM output registers only advance while enabled, so the enable must
  // stay high until every issued read has come out of the pipe.
  assign ram_en   = issue || (inflight != '0);
  assign ram_addr = addr;

  assign push     = tag_pipe[RD_LATENCY-1].valid;
  assign o_tvalid = !fifo_empty;
  assign pop      = o_tvalid && o_tready;
  assign o_tdata  = fifo_head[DWIDTH-1:0];
  assign o_tlast  = fifo_head[DWIDTH];

  // Count the pipe stages that hold a real read.
  always_comb begin
    // NOTE: assigning a default first means every path writes inflight,
    // so no latch can be inferred.
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (tag_pipe[i].valid) begin
        inflight = inflight + CNT_W'(1);
      end
    end
  end

  // Next-state logic for IDLE -> ISSUE -> DRAIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_accept) state_nxt = S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && o_tlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read address and words-remaining counter; the address wraps naturally
  // at the top of the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (cmd_accept) begin
      addr      <= cmd_addr;
      remaining <= cmd_len;
    end else if (issue) begin
      addr <= addr + AWIDTH'(1);
      if (!last_issue) begin
        remaining <= remaining - AWIDTH'(1);
      end
    end
  end

  // Tag pipe that shifts in lock-step with the RAM's enabled pipeline;
  // enabled cycles without an issue insert bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else if (ram_en) begin
      tag_pipe[0] <= '{valid: issue, last: last_issue};
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  ram_burst_reader_fifo #(
    .WIDTH (DWIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({tag_pipe[RD_LATENCY-1].last, ram_dout}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=2 share the command and ready inputs, each reads its own RAM
// model, and each output stream is checked against a scoreboard queue.
module tb_ram_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        tready;

  logic        cmd_ready_1, ram_en_1, tlast_1, tvalid_1;
  logic [7:0]  ram_addr_1;
  logic [31:0] ram_dout_1, tdata_1;
  logic        cmd_ready_2, ram_en_2, tlast_2, tvalid_2;
  logic [7:0]  ram_addr_2;
  logic [31:0] ram_dout_2, tdata_2, ram_stage_2;

  logic [31:0] mem [256];
  logic [32:0] q1[$];
  logic [32:0] q2[$];

  int tests_run;
  int tests_failed;
  int words_1;
  int mode;
  int phase;

  ram_burst_reader #(.DWIDTH(32), .AWIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_1),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en(ram_en_1), .ram_addr(ram_addr_1),
    .ram_dout(ram_dout_1), .o_tdata(tdata_1), .o_tlast(tlast_1), .o_tvalid(tvalid_1),
    .o_tready(tready)
  );

  ram_burst_reader #(.DWIDTH(32), .AWIDTH(8), .RD_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_2),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_en(ram_en_2), .ram_addr(ram_addr_2),
    .ram_dout(ram_dout_2), .o_tdata(tdata_2), .o_tlast(tlast_2), .o_tvalid(tvalid_2),
    .o_tready(tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = ram_word(8'(i));
  end

  // RAM models: output registers advance only on enabled cycles.
  always @(posedge clk) begin
    if (ram_en_1) ram_dout_1 <= mem[ram_addr_1];
    if (ram_en_2) begin
      ram_stage_2 <= mem[ram_addr_2];
      ram_dout_2  <= ram_stage_2;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready generator: 0 = always ready, 1 = repeating 1-0-0-1, 2 = random.
  initial begin
    tready = 1'b1;
    phase  = 0;
  end
  always @(posedge clk) begin
    #1;
    phase = (phase + 1) % 4;
    case (mode)
      0:       tready = 1'b1;
      1:       tready = (phase == 0) || (phase == 3);
      default: tready = ($urandom_range(0, 1) != 0);
    endcase
  end

  // Output monitor for the RD_LATENCY=1 instance.
  logic        hold_1, last_seen_1;
  logic [32:0] hold_val_1;
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst_n) begin
      hold_1      = 1'b0;
      last_seen_1 = 1'b0;
    end else begin
      if (last_seen_1) check("rdy_after_last_1", cmd_ready_1, 1);
      last_seen_1 = 1'b0;
      if (hold_1) begin
        check("hold_valid_1", tvalid_1, 1);
        check("hold_data_1", {tlast_1, tdata_1}, hold_val_1);
      end
      if (cmd_ready_1) check("idle_ram_en_1", ram_en_1, 0);
      check("credit_1", ({1'b0, u_dut1.fifo_count} + {1'b0, u_dut1.inflight}) > 4'd4, 0);
      if (tvalid_1 && tready) begin
        words_1++;
        exp = (q1.size() != 0) ? {31'b0, q1.pop_front()} : 64'hFFFF_0000_0000_0000;
        check("word_1", {tlast_1, tdata_1}, exp);
        last_seen_1 = tlast_1;
        hold_1      = 1'b0;
      end else begin
        hold_1     = tvalid_1;
        hold_val_1 = {tlast_1, tdata_1};
      end
    end
  end

  // Output monitor for the RD_LATENCY=2 instance.
  logic        hold_2, last_seen_2;
  logic [32:0] hold_val_2;
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst_n) begin
      hold_2      = 1'b0;
      last_seen_2 = 1'b0;
    end else begin
      if (last_seen_2) check("rdy_after_last_2", cmd_ready_2, 1);
      last_seen_2 = 1'b0;
      if (hold_2) begin
        check("hold_valid_2", tvalid_2, 1);
        check("hold_data_2", {tlast_2, tdata_2}, hold_val_2);
      end
      if (cmd_ready_2) check("idle_ram_en_2", ram_en_2, 0);
      check("credit_2", ({1'b0, u_dut2.fifo_count} + {1'b0, u_dut2.inflight}) > 4'd4, 0);
      if (tvalid_2 && tready) begin
        exp = (q2.size() != 0) ? {31'b0, q2.pop_front()} : 64'hFFFF_0000_0000_0000;
        check("word_2", {tlast_2, tdata_2}, exp);
        last_seen_2 = tlast_2;
        hold_2      = 1'b0;
      end else begin
        hold_2     = tvalid_2;
        hold_val_2 = {tlast_2, tdata_2};
      end
    end
  end

  // Wait for both instances to be idle, queue the expected words, and hold
  // cmd_valid across one rising edge (the accept edge).
  task automatic start_burst(input logic [7:0] a, input logic [7:0] len);
    int n;
    n = 0;
    while (!(cmd_ready_1 && cmd_ready_2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", cmd_ready_1 && cmd_ready_2, 1);
    for (int i = 0; i <= int'(len); i++) begin
      logic [7:0] ad;
      ad = a + 8'(i);
      q1.push_back({(i == int'(len)), ram_word(ad)});
      q2.push_back({(i == int'(len)), ram_word(ad)});
    end
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] a, input logic [7:0] len, input bit measure);
    logic [11:0] en1, en2, exp1, exp2;
    int lat1, lat2, n;
    start_burst(a, len);
    lat1 = -1;
    lat2 = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("busy_1", cmd_ready_1, 0);
        check("busy_2", cmd_ready_2, 0);
      end
      en1[j]  = ram_en_1;
      en2[j]  = ram_en_2;
      exp1[j] = (j <= int'(len) + 1);
      exp2[j] = (j <= int'(len) + 2);
      if (tvalid_1 && lat1 < 0) lat1 = j;
      if (tvalid_2 && lat2 < 0) lat2 = j;
    end
    if (measure) begin
      check("latency_1", lat1, 2);
      check("latency_2", lat2, 3);
      check("ram_en_seq_1", en1, exp1);
      check("ram_en_seq_2", en2, exp2);
    end
    n = 0;
    while (!(q1.size() == 0 && q2.size() == 0 && cmd_ready_1 && cmd_ready_2) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("left_1", q1.size(), 0);
    check("left_2", q2.size(), 0);
    check("done_rdy_1", cmd_ready_1, 1);
    check("done_rdy_2", cmd_ready_2, 1);
  endtask

  initial begin
    int n, w0;
    tests_run    = 0;
    tests_failed = 0;
    words_1      = 0;
    mode         = 0;
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_addr     = '0;
    cmd_len      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready_1", cmd_ready_1, 1);
    check("rst_ram_en_1", ram_en_1, 0);
    check("rst_ram_addr_1", ram_addr_1, 0);
    check("rst_tvalid_1", tvalid_1, 0);
    check("rst_tlast_1", tlast_1, 0);
    check("rst_tdata_1", tdata_1, 0);
    check("rst_cmd_ready_2", cmd_ready_2, 1);
    check("rst_ram_en_2", ram_en_2, 0);
    check("rst_tvalid_2", tvalid_2, 0);
    check("rst_tdata_2", tdata_2, 0);
    @(negedge clk) rst_n = 1'b1;

    run_burst(8'h10, 8'd3, 1'b1);   // basic burst, both latencies
    run_burst(8'hFE, 8'd3, 1'b1);   // address wrap 0xFE..0x01
    run_burst(8'h33, 8'd0, 1'b1);   // single word
    mode = 1;
    run_burst(8'h20, 8'd15, 1'b0);  // 1-0-0-1 backpressure
    mode = 2;
    run_burst(8'h90, 8'd40, 1'b0);  // random backpressure
    mode = 0;
    run_burst(8'h00, 8'd255, 1'b0); // full depth, wraps the address space

    // Reset after five words of a sixteen-word burst.
    w0 = words_1;
    start_burst(8'h80, 8'd15);
    n = 0;
    while (words_1 < w0 + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_words", words_1 - w0 >= 5, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid_1", tvalid_1, 0);
    check("mid_rst_tvalid_2", tvalid_2, 0);
    check("mid_rst_ram_en_1", ram_en_1, 0);
    check("mid_rst_ram_en_2", ram_en_2, 0);
    check("mid_rst_tlast_1", tlast_1, 0);
    check("mid_rst_cmd_ready_1", cmd_ready_1, 1);
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_burst(8'h40, 8'd7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
